// File: rtl/pzcorebus_protocol_monitor.sv
// CoreBus protocol monitor: registered sticky flags for channel stability, write-burst pairing,
// per-ID outstanding tracking, unexpected responses and overflow conditions.
module pzcorebus_protocol_monitor #(
  parameter int ID_WIDTH        = 4,
  parameter int LENGTH_WIDTH    = 4,
  parameter int CMD_WIDTH       = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int RESP_WIDTH      = 72,
  parameter int WRITE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_mcmd_valid,
  input  logic                    i_scmd_accept,
  input  logic                    i_mcmd_with_data,
  input  logic                    i_mcmd_non_posted,
  input  logic [ID_WIDTH-1:0]     i_mcmd_id,
  input  logic [LENGTH_WIDTH-1:0] i_mcmd_length,
  input  logic [CMD_WIDTH-1:0]    i_mcmd_payload,
  input  logic                    i_mdata_valid,
  input  logic                    i_sdata_accept,
  input  logic                    i_mdata_last,
  input  logic [DATA_WIDTH-1:0]   i_mdata_payload,
  input  logic                    i_sresp_valid,
  input  logic                    i_mresp_accept,
  input  logic [ID_WIDTH-1:0]     i_sresp_id,
  input  logic                    i_sresp_last,
  input  logic [RESP_WIDTH-1:0]   i_sresp_payload,
  output logic [7:0]              o_error,
  output logic                    o_error_event,
  output logic [2:0]              o_first_error,
  output logic                    o_first_valid,
  output logic [ID_WIDTH+3:0]     o_outstanding
);
  localparam int ID_COUNT = 1 << ID_WIDTH;
  localparam int BW       = LENGTH_WIDTH + 1;
  localparam int PW       = (WRITE_DEPTH > 1) ? $clog2(WRITE_DEPTH) : 1;
  localparam int FW       = $clog2(WRITE_DEPTH + 1);
  localparam int OW       = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW       = ID_WIDTH + 4;
  localparam logic [BW-1:0] BEAT_MAX  = {1'b1, {LENGTH_WIDTH{1'b0}}};
  localparam logic [BW-1:0] BEAT_NEAR = BEAT_MAX - 1'b1;
  localparam logic [FW-1:0] FIFO_FULL = FW'(WRITE_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(WRITE_DEPTH - 1);
  localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);

  logic                  mcmd_ack, mdata_ack, sresp_ack;
  logic [2:0]            stall_q, stall_d;
  logic [CMD_WIDTH-1:0]  cmd_hist_q, cmd_hist_d;
  logic [DATA_WIDTH-1:0] data_hist_q, data_hist_d;
  logic [RESP_WIDTH-1:0] resp_hist_q, resp_hist_d;
  logic                  cmd_unstable, data_unstable, resp_unstable;

  logic [BW-1:0]         beat_q, beat_d;
  logic                  too_long;
  logic [1:0]            push, do_push, fifo_full;
  logic [BW-1:0]         push_val [2];
  logic                  pop, burst_mismatch, write_overflow;
  logic [BW-1:0]         fifo_mem_q [2][WRITE_DEPTH];
  logic [BW-1:0]         fifo_mem_d [2][WRITE_DEPTH];
  logic [PW-1:0]         wr_ptr_q [2], wr_ptr_d [2];
  logic [PW-1:0]         rd_ptr_q [2], rd_ptr_d [2];
  logic [FW-1:0]         fifo_cnt_q [2], fifo_cnt_d [2];

  logic                  inc_hit, dec_hit, unexpected, out_overflow;
  logic [OW-1:0]         out_cnt_q [ID_COUNT], out_cnt_d [ID_COUNT];
  logic [SW-1:0]         out_sum_q, out_sum_d;

  logic [7:0]            err_new, err_base, err_q, err_d;
  logic                  event_q, event_d;
  logic [2:0]            first_q, first_d;
  logic                  first_valid_q, first_valid_d;

  // A stall in the previous cycle obliges the channel to hold valid and payload.
  always_comb begin
    mcmd_ack      = i_mcmd_valid & i_scmd_accept;
    mdata_ack     = i_mdata_valid & i_sdata_accept;
    sresp_ack     = i_sresp_valid & i_mresp_accept;
    stall_d       = {i_sresp_valid & ~i_mresp_accept,
                     i_mdata_valid & ~i_sdata_accept,
                     i_mcmd_valid  & ~i_scmd_accept};
    cmd_hist_d    = i_mcmd_payload;
    data_hist_d   = i_mdata_payload;
    resp_hist_d   = i_sresp_payload;
    cmd_unstable  = stall_q[0] & (~i_mcmd_valid  | (i_mcmd_payload  != cmd_hist_q));
    data_unstable = stall_q[1] & (~i_mdata_valid | (i_mdata_payload != data_hist_q));
    resp_unstable = stall_q[2] & (~i_sresp_valid | (i_sresp_payload != resp_hist_q));
  end

  always_comb begin
    beat_d      = beat_q;
    too_long    = 1'b0;
    push        = {mdata_ack & i_mdata_last, mcmd_ack & i_mcmd_with_data};
    push_val[0] = (i_mcmd_length == '0) ? BEAT_MAX : {1'b0, i_mcmd_length};
    push_val[1] = beat_q + 1'b1;
    if (mdata_ack) begin
      if (i_mdata_last) begin
        beat_d = '0;
      end else begin
        too_long = (beat_q >= BEAT_NEAR);
        if (beat_q != BEAT_MAX) beat_d = beat_q + 1'b1;
      end
    end
  end

  // FIFO 0 holds command lengths, FIFO 1 holds observed burst lengths.
  always_comb begin
    pop            = (fifo_cnt_q[0] != '0) && (fifo_cnt_q[1] != '0);
    burst_mismatch = pop && (fifo_mem_q[0][rd_ptr_q[0]] != fifo_mem_q[1][rd_ptr_q[1]]);
    write_overflow = 1'b0;
    fifo_mem_d     = fifo_mem_q;
    fifo_full      = '0;
    do_push        = '0;
    for (int f = 0; f < 2; f++) begin
      wr_ptr_d[f]   = wr_ptr_q[f];
      rd_ptr_d[f]   = rd_ptr_q[f];
      fifo_cnt_d[f] = fifo_cnt_q[f];
      fifo_full[f]  = (fifo_cnt_q[f] == FIFO_FULL);
      do_push[f]    = push[f] & (~fifo_full[f] | pop);
      if (push[f] && fifo_full[f] && !pop) write_overflow = 1'b1;
      if (do_push[f]) begin
        fifo_mem_d[f][wr_ptr_q[f]] = push_val[f];
        wr_ptr_d[f] = (wr_ptr_q[f] == PTR_LAST) ? '0 : wr_ptr_q[f] + 1'b1;
      end
      if (pop) rd_ptr_d[f] = (rd_ptr_q[f] == PTR_LAST) ? '0 : rd_ptr_q[f] + 1'b1;
      case ({do_push[f], pop})
        2'b10:   fifo_cnt_d[f] = fifo_cnt_q[f] + 1'b1;
        2'b01:   fifo_cnt_d[f] = fifo_cnt_q[f] - 1'b1;
        default: fifo_cnt_d[f] = fifo_cnt_q[f];
      endcase
    end
  end

  always_comb begin
    inc_hit      = mcmd_ack & i_mcmd_non_posted;
    dec_hit      = sresp_ack & i_sresp_last;
    unexpected   = sresp_ack && (out_cnt_q[i_sresp_id] == '0) &&
                   !(inc_hit && (i_mcmd_id == i_sresp_id));
    out_overflow = 1'b0;
    out_sum_d    = '0;
    for (int i = 0; i < ID_COUNT; i++) begin
      logic inc_i, dec_i;
      inc_i        = inc_hit && (i_mcmd_id  == ID_WIDTH'(i));
      dec_i        = dec_hit && (i_sresp_id == ID_WIDTH'(i));
      out_cnt_d[i] = out_cnt_q[i];
      if (inc_i && !dec_i) begin
        if (out_cnt_q[i] == OUT_MAX) out_overflow = 1'b1;
        else                         out_cnt_d[i] = out_cnt_q[i] + 1'b1;
      end else if (dec_i && !inc_i && (out_cnt_q[i] != '0)) begin
        out_cnt_d[i] = out_cnt_q[i] - 1'b1;
      end
      out_sum_d = out_sum_d + SW'(out_cnt_d[i]);
    end
  end

  assign err_new = {out_overflow, unexpected, too_long, write_overflow,
                    burst_mismatch, resp_unstable, data_unstable, cmd_unstable};

  // Clear drops the old flags, but errors seen in the same cycle still set.
  always_comb begin
    err_base      = i_clear ? 8'h00 : err_q;
    err_d         = err_base | err_new;
    event_d       = |(err_new & ~err_base);
    first_d       = i_clear ? 3'd0 : first_q;
    first_valid_d = i_clear ? 1'b0 : first_valid_q;
    if (!first_valid_d && (err_new != 8'h00)) begin
      first_valid_d = 1'b1;
      for (int b = 7; b >= 0; b--) begin
        if (err_new[b]) first_d = 3'(b);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q       <= '0;
      cmd_hist_q    <= '0;
      data_hist_q   <= '0;
      resp_hist_q   <= '0;
      beat_q        <= '0;
      for (int f = 0; f < 2; f++) begin
        wr_ptr_q[f]   <= '0;
        rd_ptr_q[f]   <= '0;
        fifo_cnt_q[f] <= '0;
        for (int e = 0; e < WRITE_DEPTH; e++) fifo_mem_q[f][e] <= '0;
      end
      for (int i = 0; i < ID_COUNT; i++) out_cnt_q[i] <= '0;
      out_sum_q     <= '0;
      err_q         <= '0;
      event_q       <= 1'b0;
      first_q       <= '0;
      first_valid_q <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      cmd_hist_q    <= cmd_hist_d;
      data_hist_q   <= data_hist_d;
      resp_hist_q   <= resp_hist_d;
      beat_q        <= beat_d;
      fifo_mem_q    <= fifo_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      out_cnt_q     <= out_cnt_d;
      out_sum_q     <= out_sum_d;
      err_q         <= err_d;
      event_q       <= event_d;
      first_q       <= first_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign o_error       = err_q;
  assign o_error_event = event_q;
  assign o_first_error = first_q;
  assign o_first_valid = first_valid_q;
  assign o_outstanding = out_sum_q;

endmodule

// File: tb/tb_pzcorebus_protocol_monitor.sv
// Bench for pzcorebus_protocol_monitor: directed scenarios plus random traffic against a
// queue-based reference model of the protocol rules.
module tb_pzcorebus_protocol_monitor;
  localparam int IDW = 4, LW = 4, CW = 64, DW = 64, RW = 72, WD = 4, MO = 8;

  logic i_clk, i_rst_n, i_clear;
  logic i_mcmd_valid, i_scmd_accept, i_mcmd_with_data, i_mcmd_non_posted;
  logic [IDW-1:0] i_mcmd_id;
  logic [LW-1:0]  i_mcmd_length;
  logic [CW-1:0]  i_mcmd_payload;
  logic i_mdata_valid, i_sdata_accept, i_mdata_last;
  logic [DW-1:0]  i_mdata_payload;
  logic i_sresp_valid, i_mresp_accept, i_sresp_last;
  logic [IDW-1:0] i_sresp_id;
  logic [RW-1:0]  i_sresp_payload;
  logic [7:0]     o_error;
  logic           o_error_event, o_first_valid;
  logic [2:0]     o_first_error;
  logic [IDW+3:0] o_outstanding;

  pzcorebus_protocol_monitor #(
    .ID_WIDTH(IDW), .LENGTH_WIDTH(LW), .CMD_WIDTH(CW), .DATA_WIDTH(DW), .RESP_WIDTH(RW),
    .WRITE_DEPTH(WD), .MAX_OUTSTANDING(MO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_mcmd_valid(i_mcmd_valid), .i_scmd_accept(i_scmd_accept),
    .i_mcmd_with_data(i_mcmd_with_data), .i_mcmd_non_posted(i_mcmd_non_posted),
    .i_mcmd_id(i_mcmd_id), .i_mcmd_length(i_mcmd_length), .i_mcmd_payload(i_mcmd_payload),
    .i_mdata_valid(i_mdata_valid), .i_sdata_accept(i_sdata_accept),
    .i_mdata_last(i_mdata_last), .i_mdata_payload(i_mdata_payload),
    .i_sresp_valid(i_sresp_valid), .i_mresp_accept(i_mresp_accept),
    .i_sresp_id(i_sresp_id), .i_sresp_last(i_sresp_last), .i_sresp_payload(i_sresp_payload),
    .o_error(o_error), .o_error_event(o_error_event), .o_first_error(o_first_error),
    .o_first_valid(o_first_valid), .o_outstanding(o_outstanding)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         q_cmd[$];
  int         q_data[$];
  int         m_beats;
  int         m_outs[16];
  int         m_sum;
  logic [7:0] m_err;
  logic       m_event, m_fv;
  logic [2:0] m_first;
  logic       m_stall_c, m_stall_d, m_stall_r;
  logic [CW-1:0] m_prev_c;
  logic [DW-1:0] m_prev_d;
  logic [RW-1:0] m_prev_r;

  task automatic model_reset();
    q_cmd.delete(); q_data.delete();
    m_beats = 0; m_sum = 0;
    for (int i = 0; i < 16; i++) m_outs[i] = 0;
    m_err = 8'h00; m_event = 1'b0; m_fv = 1'b0; m_first = 3'd0;
    m_stall_c = 1'b0; m_stall_d = 1'b0; m_stall_r = 1'b0;
    m_prev_c = '0; m_prev_d = '0; m_prev_r = '0;
  endtask

  task automatic model_step();
    logic [7:0] ne;
    logic [7:0] base;
    bit ca, da, ra, pop, fc, fd, inc, dec, found;
    int lenv;
    ne = 8'h00;
    ca = i_mcmd_valid && i_scmd_accept;
    da = i_mdata_valid && i_sdata_accept;
    ra = i_sresp_valid && i_mresp_accept;
    if (m_stall_c && (!i_mcmd_valid || i_mcmd_payload != m_prev_c)) ne[0] = 1'b1;
    if (m_stall_d && (!i_mdata_valid || i_mdata_payload != m_prev_d)) ne[1] = 1'b1;
    if (m_stall_r && (!i_sresp_valid || i_sresp_payload != m_prev_r)) ne[2] = 1'b1;
    pop = (q_cmd.size() > 0) && (q_data.size() > 0);
    fc  = (q_cmd.size() == WD);
    fd  = (q_data.size() == WD);
    if (pop) begin
      if (q_cmd[0] != q_data[0]) ne[3] = 1'b1;
      void'(q_cmd.pop_front());
      void'(q_data.pop_front());
    end
    if (ca && i_mcmd_with_data) begin
      lenv = (i_mcmd_length == 0) ? 16 : int'(i_mcmd_length);
      if (fc && !pop) ne[4] = 1'b1; else q_cmd.push_back(lenv);
    end
    if (da) begin
      if (i_mdata_last) begin
        if (fd && !pop) ne[4] = 1'b1; else q_data.push_back(m_beats + 1);
        m_beats = 0;
      end else begin
        if (m_beats + 1 >= 16) ne[5] = 1'b1;
        if (m_beats < 16) m_beats++;
      end
    end
    inc = ca && i_mcmd_non_posted;
    dec = ra && i_sresp_last;
    if (ra && m_outs[i_sresp_id] == 0 && !(inc && i_mcmd_id == i_sresp_id)) ne[6] = 1'b1;
    if (!(inc && dec && i_mcmd_id == i_sresp_id)) begin
      if (inc) begin
        if (m_outs[i_mcmd_id] == MO) ne[7] = 1'b1; else m_outs[i_mcmd_id]++;
      end
      if (dec && m_outs[i_sresp_id] > 0) m_outs[i_sresp_id]--;
    end
    m_sum = 0;
    for (int i = 0; i < 16; i++) m_sum += m_outs[i];
    base    = i_clear ? 8'h00 : m_err;
    m_event = ((ne & ~base) != 8'h00);
    m_err   = base | ne;
    if (i_clear) begin m_fv = 1'b0; m_first = 3'd0; end
    if (!m_fv && ne != 8'h00) begin
      m_fv = 1'b1; found = 1'b0;
      for (int b = 0; b < 8; b++) if (!found && ne[b]) begin m_first = 3'(b); found = 1'b1; end
    end
    m_stall_c = i_mcmd_valid && !i_scmd_accept;  m_prev_c = i_mcmd_payload;
    m_stall_d = i_mdata_valid && !i_sdata_accept; m_prev_d = i_mdata_payload;
    m_stall_r = i_sresp_valid && !i_mresp_accept; m_prev_r = i_sresp_payload;
  endtask

  task automatic idle();
    i_clear = 0;
    i_mcmd_valid = 0; i_scmd_accept = 0; i_mcmd_with_data = 0; i_mcmd_non_posted = 0;
    i_mcmd_id = '0; i_mcmd_length = '0; i_mcmd_payload = '0;
    i_mdata_valid = 0; i_sdata_accept = 0; i_mdata_last = 0; i_mdata_payload = '0;
    i_sresp_valid = 0; i_mresp_accept = 0; i_sresp_id = '0; i_sresp_last = 0; i_sresp_payload = '0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    idle();
    i_rst_n = 1'b0;
    model_reset();
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
  endtask

  task automatic send_cmd(input bit wd, input bit np, input int id, input int len);
    idle();
    i_mcmd_valid = 1; i_scmd_accept = 1; i_mcmd_with_data = wd; i_mcmd_non_posted = np;
    i_mcmd_id = 4'(id); i_mcmd_length = 4'(len); i_mcmd_payload = {$urandom, $urandom};
    cycle();
    idle();
  endtask

  task automatic send_beat(input bit last);
    idle();
    i_mdata_valid = 1; i_sdata_accept = 1; i_mdata_last = last;
    i_mdata_payload = {$urandom, $urandom};
    cycle();
    idle();
  endtask

  task automatic send_resp(input int id);
    idle();
    i_sresp_valid = 1; i_mresp_accept = 1; i_sresp_id = 4'(id); i_sresp_last = 1;
    i_sresp_payload = {8'($urandom), $urandom, $urandom};
    cycle();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL reset_error got=%h want=00", o_error); end
    n_vec++; if (o_error_event !== 1'b0) begin n_err++; $display("FAIL reset_event got=%b want=0", o_error_event); end
    n_vec++; if (o_first_error !== 3'd0) begin n_err++; $display("FAIL reset_first got=%0d want=0", o_first_error); end
    n_vec++; if (o_first_valid !== 1'b0) begin n_err++; $display("FAIL reset_first_valid got=%b want=0", o_first_valid); end
    n_vec++; if (o_outstanding !== '0) begin n_err++; $display("FAIL reset_outstanding got=%0d want=0", o_outstanding); end
  endtask

  task automatic test_write_pair();
    do_reset();
    send_cmd(1, 0, 2, 4);
    for (int b = 1; b <= 4; b++) send_beat(b == 4);
    cycle(); cycle();
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL write_pair_error got=%h want=00", o_error); end
    // one-beat data-first burst afterwards proves both FIFOs drained in step
    send_beat(1);
    send_cmd(1, 0, 2, 1);
    cycle(); cycle();
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL write_pair_drained got=%h want=00", o_error); end
    n_vec++; if (o_first_valid !== 1'b0) begin n_err++; $display("FAIL write_pair_first_valid got=%b want=0", o_first_valid); end
  endtask

  task automatic test_data_first();
    int ev;
    do_reset();
    ev = 0;
    send_beat(0); ev += int'(o_error_event);
    send_beat(1); ev += int'(o_error_event);
    send_cmd(1, 0, 0, 3); ev += int'(o_error_event);
    for (int c = 0; c < 4; c++) begin cycle(); ev += int'(o_error_event); end
    n_vec++; if (o_error !== 8'h08) begin n_err++; $display("FAIL data_first_error got=%h want=08", o_error); end
    n_vec++; if (o_first_error !== 3'd3) begin n_err++; $display("FAIL data_first_index got=%0d want=3", o_first_error); end
    n_vec++; if (o_first_valid !== 1'b1) begin n_err++; $display("FAIL data_first_valid got=%b want=1", o_first_valid); end
    n_vec++; if (ev != 1) begin n_err++; $display("FAIL data_first_pulses got=%0d want=1", ev); end
  endtask

  task automatic test_unstable();
    do_reset();
    i_mcmd_valid = 1; i_scmd_accept = 0; i_mcmd_payload = 64'h1234_5678_9abc_def0;
    cycle();
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL unstable_cmd_early got=%h want=00", o_error); end
    i_mcmd_payload = 64'h1234_5678_9abc_def1;
    cycle();
    n_vec++; if (o_error !== 8'h01) begin n_err++; $display("FAIL unstable_cmd got=%h want=01", o_error); end
    do_reset();
    i_mcmd_valid = 1; i_scmd_accept = 0; i_mcmd_payload = 64'h55;
    cycle(); cycle(); cycle();
    i_scmd_accept = 1;
    cycle(); idle(); cycle();
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL stable_hold got=%h want=00", o_error); end
    i_mdata_valid = 1; i_sdata_accept = 0; i_mdata_payload = 64'hAA;
    cycle();
    i_mdata_valid = 0;
    cycle();
    n_vec++; if (o_error !== 8'h02) begin n_err++; $display("FAIL unstable_data got=%h want=02", o_error); end
    idle();
    i_sresp_valid = 1; i_mresp_accept = 0; i_sresp_payload = 72'h77;
    cycle();
    i_sresp_valid = 0;
    cycle();
    n_vec++; if (o_error !== 8'h06) begin n_err++; $display("FAIL unstable_resp got=%h want=06", o_error); end
    n_vec++; if (o_first_error !== 3'd1) begin n_err++; $display("FAIL unstable_first got=%0d want=1", o_first_error); end
  endtask

  task automatic test_outstanding();
    do_reset();
    send_cmd(0, 1, 5, 1);
    n_vec++; if (o_outstanding !== 8'd1) begin n_err++; $display("FAIL outs_up1 got=%0d want=1", o_outstanding); end
    send_cmd(0, 1, 5, 1);
    n_vec++; if (o_outstanding !== 8'd2) begin n_err++; $display("FAIL outs_up2 got=%0d want=2", o_outstanding); end
    send_resp(5);
    n_vec++; if (o_outstanding !== 8'd1) begin n_err++; $display("FAIL outs_dn1 got=%0d want=1", o_outstanding); end
    send_resp(5);
    n_vec++; if (o_outstanding !== 8'd0) begin n_err++; $display("FAIL outs_dn0 got=%0d want=0", o_outstanding); end
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL outs_clean got=%h want=00", o_error); end
    send_resp(5);
    n_vec++; if (o_error !== 8'h40) begin n_err++; $display("FAIL unexpected_resp got=%h want=40", o_error); end
    n_vec++; if (o_outstanding !== 8'd0) begin n_err++; $display("FAIL outs_no_underflow got=%0d want=0", o_outstanding); end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    for (int k = 0; k < 8; k++) send_cmd(0, 1, 0, 1);
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL max_at_limit got=%h want=00", o_error); end
    send_cmd(0, 1, 0, 1);
    n_vec++; if (o_error !== 8'h80) begin n_err++; $display("FAIL max_overflow got=%h want=80", o_error); end
    n_vec++; if (o_outstanding !== 8'd8) begin n_err++; $display("FAIL max_hold got=%0d want=8", o_outstanding); end
    n_vec++; if (o_first_error !== 3'd7) begin n_err++; $display("FAIL max_first got=%0d want=7", o_first_error); end
    i_mcmd_valid = 1; i_scmd_accept = 0; i_mcmd_non_posted = 1; i_mcmd_payload = 64'h99;
    cycle();
    idle(); i_clear = 1;
    cycle();
    idle();
    n_vec++; if (o_error !== 8'h01) begin n_err++; $display("FAIL clear_setwins got=%h want=01", o_error); end
    n_vec++; if (o_first_error !== 3'd0 || o_first_valid !== 1'b1) begin n_err++; $display("FAIL clear_first got=%0d/%b want=0/1", o_first_error, o_first_valid); end
    n_vec++; if (o_error_event !== 1'b1) begin n_err++; $display("FAIL clear_event got=%b want=1", o_error_event); end
    n_vec++; if (o_outstanding !== 8'd8) begin n_err++; $display("FAIL clear_keeps_tracking got=%0d want=8", o_outstanding); end
  endtask

  task automatic test_write_overflow();
    do_reset();
    for (int k = 0; k < 4; k++) send_cmd(1, 0, 1, 2);
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL wovf_full got=%h want=00", o_error); end
    send_cmd(1, 0, 1, 2);
    n_vec++; if (o_error !== 8'h10) begin n_err++; $display("FAIL wovf_set got=%h want=10", o_error); end
    send_cmd(0, 1, 3, 1);
    send_beat(0);
    i_rst_n = 1'b0;
    model_reset();
    #2;
    n_vec++; if (o_error !== 8'h00 || o_error_event !== 1'b0) begin n_err++; $display("FAIL midreset_error got=%h/%b want=00/0", o_error, o_error_event); end
    n_vec++; if (o_first_valid !== 1'b0 || o_first_error !== 3'd0) begin n_err++; $display("FAIL midreset_first got=%0d/%b want=0/0", o_first_error, o_first_valid); end
    n_vec++; if (o_outstanding !== '0) begin n_err++; $display("FAIL midreset_outs got=%0d want=0", o_outstanding); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    cycle();
    send_cmd(1, 0, 0, 1);
    send_beat(1);
    cycle(); cycle();
    n_vec++; if (o_error !== 8'h00) begin n_err++; $display("FAIL postreset_clean got=%h want=00", o_error); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (!(i_mcmd_valid && !i_scmd_accept && $urandom_range(9) != 0)) begin
        i_mcmd_valid = 1'($urandom_range(1)); i_mcmd_with_data = 1'($urandom_range(1));
        i_mcmd_non_posted = 1'($urandom_range(1)); i_mcmd_id = 4'($urandom_range(3));
        i_mcmd_length = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
        i_mcmd_payload = {$urandom, $urandom};
      end
      if (!(i_mdata_valid && !i_sdata_accept && $urandom_range(9) != 0)) begin
        i_mdata_valid = 1'($urandom_range(1)); i_mdata_last = ($urandom_range(2) == 0);
        i_mdata_payload = {$urandom, $urandom};
      end
      if (!(i_sresp_valid && !i_mresp_accept && $urandom_range(9) != 0)) begin
        i_sresp_valid = ($urandom_range(2) == 0); i_sresp_id = 4'($urandom_range(3));
        i_sresp_last = 1'($urandom_range(1)); i_sresp_payload = {8'($urandom), $urandom, $urandom};
      end
      i_scmd_accept  = 1'($urandom_range(1));
      i_sdata_accept = 1'($urandom_range(1));
      i_mresp_accept = 1'($urandom_range(1));
      i_clear        = ($urandom_range(49) == 0);
      cycle();
      n_vec++; if (o_error !== m_err) begin n_err++; $display("FAIL rnd_error c=%0d got=%h want=%h", c, o_error, m_err); end
      n_vec++; if (o_error_event !== m_event) begin n_err++; $display("FAIL rnd_event c=%0d got=%b want=%b", c, o_error_event, m_event); end
      n_vec++; if (o_first_valid !== m_fv || o_first_error !== m_first) begin n_err++; $display("FAIL rnd_first c=%0d got=%0d/%b want=%0d/%b", c, o_first_error, o_first_valid, m_first, m_fv); end
      n_vec++; if (int'(o_outstanding) != m_sum) begin n_err++; $display("FAIL rnd_outs c=%0d got=%0d want=%0d", c, o_outstanding, m_sum); end
    end
    idle();
  endtask

  initial begin
    idle();
    i_rst_n = 1'b0;
    #1;
    test_reset();
    test_write_pair();
    test_data_first();
    test_unstable();
    test_outstanding();
    test_max_outstanding();
    test_write_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
